// File: rtl/serial_parity_rx.sv
// Serial XOR-parity receiver: start bit, DATA_W data bits LSB-first, parity bit, stop bit.
// Reports data-valid, parity-error and framing-error as one-cycle pulses after the stop-bit strobe.
module serial_parity_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                acc_q, acc_d;
    logic                perr_q, perr_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                parity_err_q, parity_err_d;
    logic                frame_err_q, frame_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            acc_q        <= 1'b0;
            perr_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            acc_q        <= acc_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        acc_d        = acc_q;
        perr_d       = perr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        // Seeding with the parity sense makes acc^parity_bit a direct mismatch flag.
                        acc_d   = (PARITY_ODD != 0);
                    end
                end
                DATA: begin
                    shreg_d[cnt_q] = rx;
                    acc_d          = acc_q ^ rx;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    perr_d  = acc_q ^ rx;
                    state_d = STOP;
                end
                STOP: begin
                    if (rx) begin
                        data_out_d   = shreg_q;
                        data_valid_d = 1'b1;
                        parity_err_d = perr_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule
